// File: rtl/matmul_pkg.sv
// Shared types and width helpers for the streaming matrix multiplier.
package matmul_pkg;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  // Bits needed to index one N*N element buffer.
  function automatic int idx_w(input int n);
    return (n * n > 2) ? $clog2(n * n) : 1;
  endfunction

  // Bits needed for the i/j/k loop counters (0..N-1).
  function automatic int k_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Accumulator width: full product plus growth for N summed terms.
  function automatic int acc_w(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_mac.sv
// Signed multiply-accumulate with synchronous clear; result wraps to element width.
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pN          = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          en,
  input  logic signed [pDATA_WIDTH-1:0] a,
  input  logic signed [pDATA_WIDTH-1:0] b,
  output logic        [pDATA_WIDTH-1:0] y
);

  localparam int ACC_W  = acc_w(pDATA_WIDTH, pN);
  localparam int PROD_W = 2 * pDATA_WIDTH;

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [PROD_W-1:0] prod;

  // Sign-extend the full-width product into the accumulator.
  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
  endfunction

  // Modulo-2^W truncation: overflow wraps, no saturation.
  function automatic logic [pDATA_WIDTH-1:0] wrap_trunc(input logic signed [ACC_W-1:0] v);
    return pDATA_WIDTH'(v);
  endfunction

  // Product and next accumulator value; clear has priority over enable.
  always_comb begin
    prod  = PROD_W'(a) * PROD_W'(b);
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q + sext_prod(prod);
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign y = wrap_trunc(acc_q);

endmodule

// File: rtl/matmul_stream.sv
// AXI-Stream N x N matrix multiplier: load A and B, compute C = A*B one MAC per
// cycle, stream C row-major with tlast on the final element.
module matmul_stream
  import matmul_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pN          = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   ss_tvalid_A,
  input  logic [pDATA_WIDTH-1:0] ss_tdata_A,
  input  logic                   ss_tlast_A,
  output logic                   ss_tready_A,
  input  logic                   ss_tvalid_B,
  input  logic [pDATA_WIDTH-1:0] ss_tdata_B,
  input  logic                   ss_tlast_B,
  output logic                   ss_tready_B,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  output logic                   err_tlast
);

  localparam int NN = pN * pN;
  localparam int IW = idx_w(pN);
  localparam int CW = IW + 1;
  localparam int KW = k_w(pN);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [KW-1:0]           i_q, i_d, j_q, j_d, k_q, k_d;
  logic                    err_q, err_d;
  logic                    in_rst_q, in_rst_d;
  logic                    acc_a, acc_b, out_hs, last_el;
  logic                    mac_clr, mac_en;
  logic [IW-1:0]           a_idx, b_idx;
  logic [pDATA_WIDTH-1:0]  mac_y;
  logic signed [pDATA_WIDTH-1:0] buf_a [NN];
  logic signed [pDATA_WIDTH-1:0] buf_b [NN];

  assign acc_a   = ss_tvalid_A && ss_tready_A;
  assign acc_b   = ss_tvalid_B && ss_tready_B;
  assign out_hs  = sm_tvalid && sm_tready;
  assign last_el = (i_q == KW'(pN - 1)) && (j_q == KW'(pN - 1));
  assign a_idx   = IW'(int'(i_q) * pN + int'(k_q));
  assign b_idx   = IW'(int'(k_q) * pN + int'(j_q));

  // Operand buffers: each accepted beat lands at its stream's current count.
  always_ff @(posedge axis_clk) begin
    if (acc_a) buf_a[cnt_a_q[IW-1:0]] <= ss_tdata_A;
    if (acc_b) buf_b[cnt_b_q[IW-1:0]] <= ss_tdata_B;
  end

  matmul_mac #(.pDATA_WIDTH(pDATA_WIDTH), .pN(pN)) u_mac (
    .clk (axis_clk),
    .rst (axis_rst),
    .clr (mac_clr),
    .en  (mac_en),
    .a   (buf_a[a_idx]),
    .b   (buf_b[b_idx]),
    .y   (mac_y)
  );

  // FSM state register.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) state_q <= S_LOAD;
    else          state_q <= state_d;
  end

  // FSM next state: load ends on beat count alone, never on tlast.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD: if (cnt_a_d == CW'(NN) && cnt_b_d == CW'(NN)) state_d = S_MAC;
      S_MAC:  if (k_q == KW'(pN - 1)) state_d = S_OUT;
      S_OUT:  if (out_hs) state_d = last_el ? S_LOAD : S_MAC;
      default: state_d = S_LOAD;
    endcase
  end

  // FSM outputs: decoded from registers only; in_rst_q keeps readies low while reset is held.
  always_comb begin
    ss_tready_A = (state_q == S_LOAD) && !in_rst_q && (cnt_a_q < CW'(NN));
    ss_tready_B = (state_q == S_LOAD) && !in_rst_q && (cnt_b_q < CW'(NN));
    sm_tvalid   = (state_q == S_OUT);
    sm_tlast    = (state_q == S_OUT) && last_el;
    sm_tdata    = mac_y;
    err_tlast   = err_q;
  end

  // Counters, loop indices, framing check and MAC control.
  always_comb begin
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    err_d    = err_q;
    in_rst_d = axis_rst;
    mac_clr  = 1'b0;
    mac_en   = 1'b0;
    if (acc_a) begin
      cnt_a_d = cnt_a_q + CW'(1);
      if (ss_tlast_A != (cnt_a_q == CW'(NN - 1))) err_d = 1'b1;
    end
    if (acc_b) begin
      cnt_b_d = cnt_b_q + CW'(1);
      if (ss_tlast_B != (cnt_b_q == CW'(NN - 1))) err_d = 1'b1;
    end
    unique case (state_q)
      S_LOAD: begin
        if (state_d == S_MAC) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          mac_clr = 1'b1;
        end
      end
      S_MAC: begin
        mac_en = 1'b1;
        k_d    = (k_q == KW'(pN - 1)) ? '0 : k_q + KW'(1);
      end
      S_OUT: begin
        if (out_hs) begin
          mac_clr = 1'b1;
          k_d     = '0;
          if (last_el) begin
            cnt_a_d = '0;
            cnt_b_d = '0;
          end else if (j_q == KW'(pN - 1)) begin
            j_d = '0;
            i_d = i_q + KW'(1);
          end else begin
            j_d = j_q + KW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Control registers.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      err_q    <= 1'b0;
      in_rst_q <= 1'b1;
    end else begin
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      err_q    <= err_d;
      in_rst_q <= in_rst_d;
    end
  end

endmodule

// File: tb/tb_matmul_stream.sv
// Scoreboard bench for matmul_stream (pN=4, 32-bit elements).
module tb_matmul_stream;

  localparam int W      = 32;
  localparam int N      = 4;
  localparam int NN     = N * N;
  localparam int BUDGET = 2000;

  logic          axis_clk = 1'b0;
  logic          axis_rst;
  logic          ss_tvalid_A, ss_tlast_A, ss_tready_A;
  logic [W-1:0]  ss_tdata_A;
  logic          ss_tvalid_B, ss_tlast_B, ss_tready_B;
  logic [W-1:0]  ss_tdata_B;
  logic          sm_tready, sm_tvalid, sm_tlast, err_tlast;
  logic [W-1:0]  sm_tdata;

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   out_cnt = 0;
  int   cyc = 0;
  int   last_in_cyc = 0;
  int   last_out_cyc = 0;
  int   tr_mode = 0;
  int   ma[NN];
  int   mb[NN];
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic         prev_last = 1'b0;

  matmul_stream #(.pDATA_WIDTH(W), .pN(N)) dut (
    .axis_clk    (axis_clk),
    .axis_rst    (axis_rst),
    .ss_tvalid_A (ss_tvalid_A),
    .ss_tdata_A  (ss_tdata_A),
    .ss_tlast_A  (ss_tlast_A),
    .ss_tready_A (ss_tready_A),
    .ss_tvalid_B (ss_tvalid_B),
    .ss_tdata_B  (ss_tdata_B),
    .ss_tlast_B  (ss_tlast_B),
    .ss_tready_B (ss_tready_B),
    .sm_tready   (sm_tready),
    .sm_tvalid   (sm_tvalid),
    .sm_tdata    (sm_tdata),
    .sm_tlast    (sm_tlast),
    .err_tlast   (err_tlast)
  );

  always #5 axis_clk = ~axis_clk;
  always @(posedge axis_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Golden C = A*B, wrapped to W bits.
  task automatic push_golden();
    exp_t e;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        longint s = 0;
        for (int k = 0; k < N; k++)
          s += longint'(ma[i*N+k]) * longint'(mb[k*N+j]);
        e.data = s[W-1:0];
        e.last = (i == N-1) && (j == N-1);
        sb.push_back(e);
      end
  endtask

  task automatic drive_stream(input bit sel_b, input logic [NN-1:0] tl, input bit gaps);
    int waited;
    bit took;
    for (int n = 0; n < NN; n++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        if (sel_b) ss_tvalid_B = 1'b0; else ss_tvalid_A = 1'b0;
        @(posedge axis_clk); #1;
      end
      if (sel_b) begin
        ss_tvalid_B = 1'b1; ss_tdata_B = mb[n]; ss_tlast_B = tl[n];
      end else begin
        ss_tvalid_A = 1'b1; ss_tdata_A = ma[n]; ss_tlast_A = tl[n];
      end
      waited = 0;
      took = 1'b0;
      while (!took && waited < BUDGET) begin
        @(negedge axis_clk);
        took = sel_b ? ss_tready_B : ss_tready_A;
        @(posedge axis_clk); #1;
        waited++;
      end
      if (!took) begin
        check(sel_b ? "b_tready_wait" : "a_tready_wait", sel_b ? ss_tready_B : ss_tready_A, 1);
        break;
      end
      if (cyc > last_in_cyc) last_in_cyc = cyc;
    end
    if (sel_b) begin ss_tvalid_B = 1'b0; ss_tlast_B = 1'b0; end
    else begin ss_tvalid_A = 1'b0; ss_tlast_A = 1'b0; end
  endtask

  task automatic run_pair(input logic [NN-1:0] tla, input logic [NN-1:0] tlb, input bit gaps);
    push_golden();
    fork
      drive_stream(1'b0, tla, gaps);
      drive_stream(1'b1, tlb, gaps);
    join
  endtask

  task automatic wait_outputs(input int target);
    int n = 0;
    while (out_cnt < target && n < 5000) begin
      @(posedge axis_clk); #1;
      n++;
    end
    check("out_count", out_cnt, target);
  endtask

  task automatic fill_random();
    for (int n = 0; n < NN; n++) begin
      ma[n] = int'($urandom);
      mb[n] = int'($urandom_range(0, 2000)) - 1000;
    end
  endtask

  // Output ready generator.
  initial begin
    sm_tready = 1'b0;
    forever begin
      @(posedge axis_clk); #1;
      if (tr_mode == 0)      sm_tready = 1'b1;
      else if (tr_mode == 1) sm_tready = 1'($urandom_range(0, 1));
    end
  end

  // Output monitor: scoreboard compare on handshake, stability under stall.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge axis_clk);
      if (axis_rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", sm_tvalid, 1);
          check("hold_data", sm_tdata, prev_data);
          check("hold_last", sm_tlast, prev_last);
        end
        if (sm_tvalid && sm_tready) begin
          check("sb_nonempty", sb.size() != 0, 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("c_data", sm_tdata, e.data);
            check("c_last", sm_tlast, e.last);
          end
          out_cnt++;
          last_out_cyc = cyc + 1;
        end
        prev_stall = sm_tvalid && !sm_tready;
        prev_data  = sm_tdata;
        prev_last  = sm_tlast;
      end
    end
  end

  initial begin : stim
    int base;
    int n;
    axis_rst = 1'b1;
    ss_tvalid_A = 1'b0; ss_tdata_A = '0; ss_tlast_A = 1'b0;
    ss_tvalid_B = 1'b0; ss_tdata_B = '0; ss_tlast_B = 1'b0;
    repeat (3) @(posedge axis_clk);
    #1;
    check("rst_tready_a", ss_tready_A, 0);
    check("rst_tready_b", ss_tready_B, 0);
    check("rst_tvalid", sm_tvalid, 0);
    check("rst_tlast", sm_tlast, 0);
    check("rst_tdata", sm_tdata, 0);
    check("rst_err", err_tlast, 0);
    axis_rst = 1'b0;
    @(posedge axis_clk); #1;
    check("post_rst_tready_a", ss_tready_A, 1);
    check("post_rst_tready_b", ss_tready_B, 1);

    // Identity times 1..16, full-rate, latency measured.
    for (int i = 0; i < NN; i++) begin
      ma[i] = (i / N == i % N) ? 1 : 0;
      mb[i] = i + 1;
    end
    tr_mode = 0;
    last_in_cyc = 0;
    run_pair(16'h8000, 16'h8000, 1'b0);
    wait_outputs(16);
    check("latency", last_out_cyc - last_in_cyc, 80);
    check("err_clean", err_tlast, 0);

    // All-2 times all-3, A fully loaded before B starts.
    for (int i = 0; i < NN; i++) begin ma[i] = 2; mb[i] = 3; end
    push_golden();
    drive_stream(1'b0, 16'h8000, 1'b0);
    check("a_full_ready_low", ss_tready_A, 0);
    check("b_still_ready", ss_tready_B, 1);
    drive_stream(1'b1, 16'h8000, 1'b0);
    wait_outputs(32);

    // Signed product and wrap-around.
    for (int i = 0; i < NN; i++) begin ma[i] = 0; mb[i] = 0; end
    ma[0] = -1; mb[0] = 5;
    run_pair(16'h8000, 16'h8000, 1'b0);
    wait_outputs(48);
    ma[0] = 32'h0001_0000; mb[0] = 32'h0001_0000;
    run_pair(16'h8000, 16'h8000, 1'b0);
    wait_outputs(64);

    // Random back-pressure, two pairs back-to-back.
    tr_mode = 1;
    fill_random();
    run_pair(16'h8000, 16'h8000, 1'b1);
    fill_random();
    run_pair(16'h8000, 16'h8000, 1'b1);
    wait_outputs(96);

    // Framing errors: extra tlast on A beat 5, missing tlast on B beat 15.
    tr_mode = 0;
    fill_random();
    run_pair(16'h8020, 16'h0000, 1'b0);
    check("err_set", err_tlast, 1);
    wait_outputs(112);
    check("err_sticky", err_tlast, 1);

    // Reset while element 7 waits in OUT.
    base = out_cnt;
    fill_random();
    run_pair(16'h8000, 16'h8000, 1'b0);
    n = 0;
    while (out_cnt < base + 7 && n < BUDGET) begin
      @(posedge axis_clk); #1;
      n++;
    end
    tr_mode = 2;
    sm_tready = 1'b0;
    n = 0;
    while (!sm_tvalid && n < BUDGET) begin
      @(posedge axis_clk); #1;
      n++;
    end
    check("stall_valid", sm_tvalid, 1);
    check("stall_last", sm_tlast, 0);
    check("err_before_rst", err_tlast, 1);
    axis_rst = 1'b1;
    @(posedge axis_clk); #1;
    check("midrst_tvalid", sm_tvalid, 0);
    check("midrst_tlast", sm_tlast, 0);
    check("midrst_tdata", sm_tdata, 0);
    check("midrst_err", err_tlast, 0);
    check("midrst_tready_a", ss_tready_A, 0);
    check("midrst_tready_b", ss_tready_B, 0);
    axis_rst = 1'b0;
    sb.delete();
    @(posedge axis_clk); #1;
    check("midrst_after_a", ss_tready_A, 1);
    check("midrst_after_b", ss_tready_B, 1);
    tr_mode = 0;
    fill_random();
    run_pair(16'h8000, 16'h8000, 1'b0);
    wait_outputs(base + 7 + 16);
    check("err_after_rst", err_tlast, 0);
    check("sb_left", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
